gen_muestreo_param: RTL and testbench
=====================================

# gen_muestreo_param

Parametrised sample-clock generator for the FIR audio filter datapath. Divides `clk_medio` by a run-time programmable ratio to produce the square-wave sample clock `clk_lento`, a one-cycle sample strobe `tick`, and a channel/slot index with frame strobe for multi-channel (e.g. stereo) sample scheduling. The divisor is double-buffered and changes only on a period boundary, so the output clock never glitches.

## Interface
- `CNT_W`, 8: width of the divisor and the internal period counter; maximum period is 2^CNT_W−1 cycles.
- `DIV_RST`, 8: divisor loaded at reset; must be ≥2.
- `N_CH`, 2: channel slots per frame, ≥1.
- `CH_W`, `$clog2(N_CH)` with a minimum of 1: width of `canal`.

Ports:
- `clk_medio`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `en`  in  1  count enable; 0 freezes all state.
- `div_i`  in  CNT_W  requested period in `clk_medio` cycles; sampled only at wrap.
- `clk_lento`  out  1  registered sample clock, high phase first.
- `tick`  out  1  registered one-cycle pulse at each period start.
- `canal`  out  CH_W  current channel slot, 0..N_CH−1.
- `trama`  out  1  registered pulse coincident with the `tick` that returns `canal` to 0.
- `div_err`  out  1  sticky flag; set when a `div_i` < 2 is loaded.

## Operation
- State: `cnt` (CNT_W bits), `div_act` (CNT_W bits), `canal`, and the output registers.
- Reset (`reset`=1 at an edge; it overrides `en`):
  - `cnt`=0, `div_act`=`DIV_RST`.
  - `clk_lento`=1, `tick`=0, `canal`=0, `trama`=0, `div_err`=0.
- Edge with `en`=1, `reset`=0:
  - Wrap: when `cnt`==`div_act`−1, `cnt_n`=0; otherwise `cnt_n`=`cnt`+1.
  - On wrap, `div_act` loads max(`div_i`, 2). If `div_i`<2, `div_err` is set and holds until reset.
  - H = `div_act_n` − (`div_act_n`>>1), i.e. ceil(div/2).
  - `clk_lento` = (`cnt_n` < H). For odd divisors the high phase is one cycle longer than the low phase.
  - `tick` = (`cnt_n`==0).
  - On a tick, `canal` advances by 1, wrapping from N_CH−1 to 0. `trama` = tick AND (`canal` wraps to 0).
  - With N_CH=1, `canal` stays 0 and `trama` = `tick`.
- Edge with `en`=0: `cnt`, `div_act`, `canal` and `clk_lento` hold; `tick` and `trama` are forced to 0.
- Divisor change mid-period: no effect until the next wrap. The current period completes at the old length.
- Arithmetic: all unsigned and wrap-free. `cnt` never exceeds `div_act`−1 because `div_act` only changes when `cnt_n`=0.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- Reset state is the start of a high phase at `cnt`=0, but no `tick` is issued for it.
- The first `tick` comes `div_act` enabled edges after reset is released.
- Period of `tick` and `clk_lento` = `div_act` enabled cycles.
- Each `tick` rises on the same edge as `clk_lento` going 0→1.
- Latency of a `div_i` change: takes effect from the period starting at the first wrap after the change; periods already in progress are unaffected.
- `reset` asserted mid-period: the next edge forces the reset state; the partial period is discarded.
- `en` dropped for k cycles: the period is stretched by exactly k cycles; the phase is otherwise preserved.

## Test plan
- Reset, `div_i`=8, N_CH=2, `en`=1 → `clk_lento` high 4 / low 4 cycles. `tick` on enabled edges 8, 16, 24. `canal` 0→1→0. `trama` on edge 16 only.
- `div_i`=5 → `clk_lento` high 3, low 2. `tick` every 5 cycles. `div_err`=0.
- Change `div_i` from 8 to 4 at `cnt`=2 → current period still ends at 8 cycles, then 4-cycle periods with 2/2 duty.
- `div_i`=1 (and separately 0) loaded at a wrap → `div_act`=2, `clk_lento` toggles every cycle, `div_err`=1 and stays 1 until `reset`.
- `en` low for 3 cycles at `cnt`=5 with div 8 → that period lasts 11 cycles, `tick`/`trama` are 0 throughout, then normal 8-cycle periods.
- `reset` pulsed for one edge at `cnt`=6 with `canal`=1 → next cycle `clk_lento`=1, `tick`=0, `canal`=0, `div_act`=`DIV_RST`. First `tick` follows 8 enabled edges later.

Source files
------------

// File: rtl/gen_muestreo_param.sv
// Sample-clock generator: divides clk_medio by a run-time divisor into a glitch-free
// square wave, a period-start strobe and a per-frame channel slot index.
module gen_muestreo_param #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned DIV_RST = 8,
  parameter int unsigned N_CH    = 2,
  parameter int unsigned CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk_medio,
  input  logic             reset,
  input  logic             en,
  input  logic [CNT_W-1:0] div_i,
  output logic             clk_lento,
  output logic             tick,
  output logic [CH_W-1:0]  canal,
  output logic             trama,
  output logic             div_err
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_act_q, div_act_d;
  logic [CNT_W-1:0] div_ld;
  logic [CNT_W-1:0] high_len;
  logic [CH_W-1:0]  canal_d;
  logic             wrap;
  logic             div_bad;
  logic             canal_last;

  always_comb begin
    wrap       = (cnt_q == div_act_q - CNT_W'(1));
    div_bad    = (div_i < CNT_W'(2));
    div_ld     = div_bad ? CNT_W'(2) : div_i;
    cnt_d      = wrap ? '0 : cnt_q + CNT_W'(1);
    // The divisor only switches at a wrap, so the running period is never cut short.
    div_act_d  = wrap ? div_ld : div_act_q;
    high_len   = div_act_d - (div_act_d >> 1);
    canal_last = (canal == CH_W'(N_CH - 1));
    canal_d    = canal;
    if (wrap) begin
      canal_d = canal_last ? '0 : canal + CH_W'(1);
    end
  end

  always_ff @(posedge clk_medio) begin
    if (reset) begin
      cnt_q     <= '0;
      div_act_q <= CNT_W'(DIV_RST);
      clk_lento <= 1'b1;
      tick      <= 1'b0;
      canal     <= '0;
      trama     <= 1'b0;
      div_err   <= 1'b0;
    end else if (en) begin
      cnt_q     <= cnt_d;
      div_act_q <= div_act_d;
      clk_lento <= (cnt_d < high_len);
      tick      <= wrap;
      canal     <= canal_d;
      trama     <= wrap && canal_last;
      if (wrap && div_bad) begin
        div_err <= 1'b1;
      end
    end else begin
      tick  <= 1'b0;
      trama <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gen_muestreo_param.sv
// Bench for gen_muestreo_param: fixed vector table, hand-written corner sequences and
// randomized stimulus checked against a period-position reference model.
module tb_gen_muestreo_param;

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned DIV_RST = 8;
  localparam int unsigned N_CH    = 2;
  localparam int unsigned CH_W    = 1;

  logic             clk_medio = 1'b0;
  logic             reset     = 1'b0;
  logic             en        = 1'b0;
  logic [CNT_W-1:0] div_i     = 8'd8;
  logic             clk_lento;
  logic             tick;
  logic [CH_W-1:0]  canal;
  logic             trama;
  logic             div_err;

  gen_muestreo_param #(
    .CNT_W  (CNT_W),
    .DIV_RST(DIV_RST),
    .N_CH   (N_CH),
    .CH_W   (CH_W)
  ) dut (
    .clk_medio(clk_medio),
    .reset    (reset),
    .en       (en),
    .div_i    (div_i),
    .clk_lento(clk_lento),
    .tick     (tick),
    .canal    (canal),
    .trama    (trama),
    .div_err  (div_err)
  );

  always #5 clk_medio = ~clk_medio;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: position inside the current period and that period's length.
  int m_pos, m_per, m_ch;
  bit m_clk, m_tick, m_trama, m_err;

  typedef struct {
    logic       r;
    logic       e;
    logic [7:0] d;
    logic [4:0] exp;  // {clk_lento, tick, canal, trama, div_err}
  } vec_t;

  vec_t tbl[$];

  function automatic logic [4:0] outs();
    return {clk_lento, tick, canal, trama, div_err};
  endfunction

  task automatic check5(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got {clk,tick,canal,trama,err}=%b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic e, input logic [7:0] d);
    if (r) begin
      m_pos = 0; m_per = DIV_RST; m_clk = 1; m_tick = 0; m_ch = 0; m_trama = 0; m_err = 0;
    end else if (e) begin
      m_pos++;
      m_tick  = 0;
      m_trama = 0;
      if (m_pos >= m_per) begin
        m_pos = 0;
        m_per = (int'(d) < 2) ? 2 : int'(d);
        if (int'(d) < 2) m_err = 1;
        m_tick  = 1;
        m_ch    = (m_ch + 1) % N_CH;
        m_trama = (m_ch == 0);
      end
      m_clk = (m_pos < (m_per + 1) / 2);
    end else begin
      m_tick  = 0;
      m_trama = 0;
    end
  endtask

  // Inputs change at the falling edge; outputs are compared at the next falling edge.
  task automatic step(input logic r, input logic e, input logic [7:0] d);
    reset = r;
    en    = e;
    div_i = d;
    @(posedge clk_medio);
    model_edge(r, e, d);
    @(negedge clk_medio);
    check5("model", outs(), {m_clk, m_tick, CH_W'(m_ch), m_trama, m_err});
  endtask

  // Enabled edges until the next tick, bounded by maxc.
  task automatic gap(input logic [7:0] d, input int maxc, output int n);
    n = 0;
    do begin
      step(1'b0, 1'b1, d);
      n++;
    end while (!tick && n < maxc);
    if (!tick) check_int("tick_timeout", 0, 1);
  endtask

  task automatic add(input logic r, input logic e, input logic [7:0] d, input logic [4:0] x);
    vec_t v;
    v.r = r; v.e = e; v.d = d; v.exp = x;
    tbl.push_back(v);
  endtask

  initial begin
    int n;
    int tot;
    logic [7:0] rd;

    // Vector table: div 3 after a default 8 period, en hold, then div 1 clamped to 2.
    add(1, 1, 8'd3, 5'b10000);
    for (int i = 0; i < 3; i++) add(0, 1, 8'd3, 5'b10000);
    for (int i = 0; i < 4; i++) add(0, 1, 8'd3, 5'b00000);
    add(0, 1, 8'd3, 5'b11100);
    add(0, 1, 8'd3, 5'b10100);
    add(0, 1, 8'd3, 5'b00100);
    add(0, 1, 8'd3, 5'b11010);
    add(0, 0, 8'd3, 5'b10000);
    add(0, 1, 8'd1, 5'b10000);
    add(0, 1, 8'd1, 5'b00000);
    add(0, 1, 8'd1, 5'b11101);
    add(0, 1, 8'd1, 5'b00101);
    add(0, 1, 8'd1, 5'b11011);
    add(1, 0, 8'd1, 5'b10000);
    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].e, tbl[i].d);
      check5($sformatf("vec[%0d]", i), outs(), tbl[i].exp);
    end

    // Divisor 8 -> 4 at cnt=2: the running period still lasts 8.
    step(1, 1, 8'd8);
    step(0, 1, 8'd8);
    step(0, 1, 8'd8);
    gap(8'd4, 20, n);
    check_int("div_change_first_gap", n, 6);
    gap(8'd4, 20, n);
    check_int("div_change_new_gap", n, 4);
    step(0, 1, 8'd4);
    check_int("duty4_high", int'(clk_lento), 1);
    step(0, 1, 8'd4);
    check_int("duty4_low", int'(clk_lento), 0);

    // div 5: high 3, low 2, no error.
    step(1, 1, 8'd5);
    gap(8'd5, 20, n);
    tot = 0;
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 8'd5);
      tot += int'(clk_lento);
    end
    check_int("div5_high_cycles", tot, 3);
    check_int("div5_err", int'(div_err), 0);

    // en low for 3 cycles at cnt=5 stretches the period to 11 cycles.
    step(1, 1, 8'd8);
    for (int i = 0; i < 5; i++) step(0, 1, 8'd8);
    tot = 5;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 8'd8);
      check_int("en_low_tick", int'(tick | trama), 0);
      tot++;
    end
    gap(8'd8, 20, n);
    check_int("stretched_period", tot + n, 11);
    gap(8'd8, 20, n);
    check_int("after_stretch_period", n, 8);

    // Reset at cnt=6 with canal=1, then first tick after 8 edges.
    step(1, 1, 8'd8);
    gap(8'd8, 20, n);
    check_int("canal_one", int'(canal), 1);
    for (int i = 0; i < 6; i++) step(0, 1, 8'd8);
    step(1, 1, 8'd8);
    check5("mid_reset_state", outs(), 5'b10000);
    gap(8'd8, 20, n);
    check_int("post_reset_first_tick", n, 8);

    // div 0 loaded at a wrap: clamps to 2 and the error sticks.
    gap(8'd0, 20, n);
    check_int("div0_err", int'(div_err), 1);
    gap(8'd9, 20, n);
    check_int("div0_clamped_period", n, 2);
    gap(8'd9, 20, n);
    check_int("div0_err_sticky", int'(div_err), 1);

    // Randomized run against the model.
    rd = 8'd6;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) rd = 8'($urandom_range(0, 12));
      if ($urandom_range(0, 199) == 0) rd = 8'($urandom_range(13, 40));
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 99) < 85), rd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
